// File: rtl/dyn_tmr_ctrl.sv
// dyn_tmr_ctrl -- dynamic TMR enable controller.
//   Runs the primary replica alone (SIMPLEX) and brings up the two spare
//   replicas when enough proximity sensors fire or when the voter error
//   rate of the last completed window is too high. After a warm-up the
//   voted result is flagged valid. Once the trigger clears, the block
//   either drops straight back to SIMPLEX or, with the optional hysteresis
//   build, waits out a cool-down first.
//
// Build option:
//   DTMR_HYST_EN  defined   -> COOL state with HOLD-cycle cool-down
//                 undefined -> TMR returns to SIMPLEX as soon as trig drops
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   sens      in   [N_SENS] sensor triggers
//   err_pulse in   voter mismatch flag, one count per cycle while high
//   en        out  [3] replica enables, bit0 = primary
//   state     out  1 = TMR voting valid
//   mode      out  [2] 0 SIMPLEX, 1 WARM, 2 TMR, 3 COOL
//   err_rate  out  [CW] error count of the last completed window
module dyn_tmr_ctrl #(
  parameter int N_SENS   = 4,
  parameter int SENS_THR = 3,
  parameter int WIN      = 16,
  parameter int ERR_THR  = 5,
  parameter int WARM     = 4,
  parameter int HOLD     = 32,
  localparam int CW      = $clog2(WIN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SENS-1:0] sens,
  input  logic              err_pulse,
  output logic [2:0]        en,
  output logic              state,
  output logic [1:0]        mode,
  output logic [CW-1:0]     err_rate
);

  localparam int WW   = $clog2(WIN);
  localparam int PW   = $clog2(N_SENS + 1);
  // One counter serves both the warm-up and the cool-down.
  localparam int FMAX = (WARM > HOLD) ? WARM : HOLD;
  localparam int FW   = $clog2(FMAX + 1);

  typedef enum logic [1:0] {
    S_SIMPLEX = 2'd0,
    S_WARM    = 2'd1,
    S_TMR     = 2'd2,
    S_COOL    = 2'd3
  } st_e;

  st_e           st_q, st_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] err_rate_q, err_rate_d;

  logic [PW-1:0] pop;
  logic [CW:0]   err_sum;
  logic [CW-1:0] err_sat;
  logic          win_last;
  logic          trig;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SENS; i++) pop = pop + PW'(sens[i]);
  end

  assign trig = (int'(pop) >= SENS_THR) || (int'(err_rate_q) > ERR_THR);

  // Error window: the pulse of the closing cycle is folded into the
  // published rate so it is never carried into the next window.
  always_comb begin
    err_sum    = {1'b0, err_cnt_q} + (CW+1)'(err_pulse);
    err_sat    = err_sum[CW] ? '1 : err_sum[CW-1:0];
    win_last   = (win_cnt_q == WW'(WIN - 1));
    win_cnt_d  = win_last ? '0 : win_cnt_q + WW'(1);
    err_cnt_d  = win_last ? '0 : err_sat;
    err_rate_d = win_last ? err_sat : err_rate_q;
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      S_SIMPLEX: begin
        cnt_d = '0;
        if (trig) st_d = S_WARM;
      end
      // Warm-up always completes, even if trig drops meanwhile.
      S_WARM: begin
        if (cnt_q == FW'(WARM - 1)) begin
          st_d  = S_TMR;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + FW'(1);
        end
      end
      S_TMR: begin
        cnt_d = '0;
        if (!trig) begin
`ifdef DTMR_HYST_EN
          st_d = S_COOL;
`else
          st_d = S_SIMPLEX;
`endif
        end
      end
`ifdef DTMR_HYST_EN
      S_COOL: begin
        if (trig) begin
          st_d  = S_TMR;
          cnt_d = '0;
        end else if (cnt_q == FW'(HOLD - 1)) begin
          st_d  = S_SIMPLEX;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + FW'(1);
        end
      end
`endif
      // Code 3 without hysteresis is unreachable; recover to SIMPLEX.
      default: begin
        st_d  = S_SIMPLEX;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= S_SIMPLEX;
      cnt_q      <= '0;
      win_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_rate_q <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      win_cnt_q  <= win_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_rate_q <= err_rate_d;
    end
  end

  assign en       = (st_q == S_SIMPLEX) ? 3'b001 : 3'b111;
  assign state    = (st_q == S_TMR) || (st_q == S_COOL);
  assign mode     = st_q;
  assign err_rate = err_rate_q;

endmodule

// File: tb/tb_dyn_tmr_ctrl.sv
module tb_dyn_tmr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sens;
  logic       err_pulse;
  logic [2:0] en;
  logic       state;
  logic [1:0] mode;
  logic [4:0] err_rate;

  dyn_tmr_ctrl dut (
    .clk(clk), .rst(rst), .sens(sens), .err_pulse(err_pulse),
    .en(en), .state(state), .mode(mode), .err_rate(err_rate)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rel = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      name;
    logic [1:0] mode;
    logic [2:0] en;
    logic       st;
    logic [4:0] rate;
  } exp_t;

  exp_t sbq[$];

  task automatic cmp(input string nm, input logic [1:0] m, input logic [2:0] e,
                     input logic s, input logic [4:0] r, input bit stale);
    n_tests++;
    if (stale || mode !== m || en !== e || state !== s || err_rate !== r) begin
      n_fail++;
      $display("FAIL %s: got mode=%0d en=%b state=%b err_rate=%0d, want mode=%0d en=%b state=%b err_rate=%0d%s",
               nm, mode, en, state, err_rate, m, e, s, r, stale ? " (missed)" : "");
    end
  endtask

  // Expected response due d clock edges from now.
  task automatic exp_at(input int d, input string nm, input logic [1:0] m,
                        input logic [2:0] e, input logic s, input logic [4:0] r);
    exp_t x;
    x.due = cyc + d; x.name = nm; x.mode = m; x.en = e; x.st = s; x.rate = r;
    sbq.push_back(x);
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].due <= cyc) begin
        cmp(sbq[i].name, sbq[i].mode, sbq[i].en, sbq[i].st, sbq[i].rate, sbq[i].due < cyc);
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until the window counter holds k (counted from reset release).
  task automatic to_win(input int k);
    while (((cyc - rel) % 16) != k) tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int base;

  initial begin
    rst = 1'b1; sens = '0; err_pulse = 1'b0;
    tick(2);
    exp_at(0, "reset", 2'd0, 3'b001, 1'b0, 5'd0);
    @(negedge clk); #1;
    rst = 1'b0; rel = cyc;
    tick(1);

    // Sensor trigger for one cycle: WARM for 4 cycles, then TMR.
    base = cyc;
    exp_at(1, "sens_warm", 2'd1, 3'b111, 1'b0, 5'd0);
    exp_at(4, "sens_warm_end", 2'd1, 3'b111, 1'b0, 5'd0);
    exp_at(5, "sens_tmr", 2'd2, 3'b111, 1'b1, 5'd0);
`ifdef DTMR_HYST_EN
    exp_at(6, "tmr_to_cool", 2'd3, 3'b111, 1'b1, 5'd0);
    exp_at(37, "cool_last", 2'd3, 3'b111, 1'b1, 5'd0);
    exp_at(38, "cool_to_simplex", 2'd0, 3'b001, 1'b0, 5'd0);
`else
    exp_at(6, "tmr_drop_simplex", 2'd0, 3'b001, 1'b0, 5'd0);
`endif
    sens = 4'b0111; tick(1); sens = '0; tick(44);

`ifdef DTMR_HYST_EN
    // Re-trigger after 20 COOL cycles, then a full cool-down.
    exp_at(25, "cool_20", 2'd3, 3'b111, 1'b1, 5'd0);
    exp_at(26, "cool_retrig", 2'd2, 3'b111, 1'b1, 5'd0);
    exp_at(27, "cool_again", 2'd3, 3'b111, 1'b1, 5'd0);
    exp_at(58, "cool_hold_last", 2'd3, 3'b111, 1'b1, 5'd0);
    exp_at(59, "cool_hold_done", 2'd0, 3'b001, 1'b0, 5'd0);
    sens = 4'b0111; tick(1); sens = '0; tick(24);
    sens = 4'b0111; tick(1); sens = '0; tick(40);
`endif

    // Six errors in one window: rate 6 > 5 forces TMR.
    to_win(0);
    exp_at(15, "err6_pre", 2'd0, 3'b001, 1'b0, 5'd0);
    exp_at(16, "err6_close", 2'd0, 3'b001, 1'b0, 5'd6);
    exp_at(17, "err6_warm", 2'd1, 3'b111, 1'b0, 5'd6);
    exp_at(21, "err6_tmr", 2'd2, 3'b111, 1'b1, 5'd6);
    exp_at(32, "err6_next_win", 2'd2, 3'b111, 1'b1, 5'd0);
`ifdef DTMR_HYST_EN
    exp_at(33, "err6_release", 2'd3, 3'b111, 1'b1, 5'd0);
`else
    exp_at(33, "err6_release", 2'd0, 3'b001, 1'b0, 5'd0);
`endif
    err_pulse = 1'b1; tick(6); err_pulse = 1'b0; tick(64);

    // Five errors: at threshold, not above it.
    to_win(0);
    exp_at(16, "err5_close", 2'd0, 3'b001, 1'b0, 5'd5);
    exp_at(17, "err5_no_trig", 2'd0, 3'b001, 1'b0, 5'd5);
    exp_at(20, "err5_still", 2'd0, 3'b001, 1'b0, 5'd5);
    exp_at(32, "err5_next_win", 2'd0, 3'b001, 1'b0, 5'd0);
    err_pulse = 1'b1; tick(5); err_pulse = 1'b0; tick(40);

    // Full-window errors, then a single pulse in the last window cycle.
    to_win(0);
    exp_at(16, "err16_close", 2'd0, 3'b001, 1'b0, 5'd16);
    exp_at(17, "err16_warm", 2'd1, 3'b111, 1'b0, 5'd16);
    exp_at(21, "err16_tmr", 2'd2, 3'b111, 1'b1, 5'd16);
    exp_at(32, "last_cycle_pulse", 2'd2, 3'b111, 1'b1, 5'd1);
`ifdef DTMR_HYST_EN
    exp_at(33, "last_pulse_release", 2'd3, 3'b111, 1'b1, 5'd1);
    exp_at(48, "pulse_not_carried", 2'd3, 3'b111, 1'b1, 5'd0);
`else
    exp_at(33, "last_pulse_release", 2'd0, 3'b001, 1'b0, 5'd1);
    exp_at(48, "pulse_not_carried", 2'd0, 3'b001, 1'b0, 5'd0);
`endif
    err_pulse = 1'b1; tick(16); err_pulse = 1'b0;
    tick(15); err_pulse = 1'b1; tick(1); err_pulse = 1'b0;
    tick(38);

    // Asynchronous reset in the middle of WARM.
    exp_at(1, "pre_rst_warm", 2'd1, 3'b111, 1'b0, 5'd0);
    sens = 4'b0111; tick(1); sens = '0; tick(1);
    #2 rst = 1'b1;
    #1 cmp("async_rst_warm", 2'd0, 3'b001, 1'b0, 5'd0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0; rel = cyc;
    tick(1);
    exp_at(0, "post_rst", 2'd0, 3'b001, 1'b0, 5'd0);
    tick(3);

    for (int k = 0; k < 200 && sbq.size() > 0; k++) tick(1);
    if (sbq.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expectations never checked, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
